sprite_merge_sched: RTL

- Per-pixel scheduler and pipeline around the alpha-blend datapath of the background module.
- Accepts the SDRAM background pixel stream and tracks the raster position.
- Arbitrates which of NUM_SPRITES sprites owns each pixel, fetches that sprite's RGBA from sprite memory, blends, and streams merged RGB to the display sink with valid/ready backpressure.
- Sprite positions and enables are double-buffered and swapped at frame start.

---
 rtl/sprite_pkg.sv | 30 +++
 rtl/pixel_blend.sv | 34 +++
 rtl/sprite_merge_sched.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite merge scheduler.
package sprite_pkg;

  localparam int COORD_W = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } rgba_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               en;
  } spr_cfg_t;

  // Sprite memory address is {slot, row, col}.
  function automatic int spr_addr_w(input int n, input int h, input int w);
    return $clog2(n) + $clog2(h) + $clog2(w);
  endfunction

endpackage

// File: rtl/pixel_blend.sv
// Combinational 3-channel alpha blend of a sprite texel over a background pixel.
module pixel_blend
  import sprite_pkg::*;
(
  input  rgb_t  bg,
  input  rgba_t spr,
  input  logic  hit,
  output rgb_t  rgb
);

  logic [7:0] a;
  logic [8:0] ap;

  // Stretch alpha so that 255 maps to 256 (pure sprite) and 0 stays 0 (pure bg).
  assign a  = hit ? spr.a : 8'd0;
  assign ap = {1'b0, a} + {8'd0, a[7]};

  // Truncating weighted sum; both weights add to 256 so the sum fits in 16 bits.
  function automatic logic [7:0] blend_ch(input logic [7:0] s, input logic [7:0] b,
                                          input logic [8:0] w);
    logic [16:0] s17, b17, w17, nw17, t;
    s17  = {9'd0, s};
    b17  = {9'd0, b};
    w17  = {8'd0, w};
    nw17 = 17'd256 - w17;
    t    = s17 * w17 + b17 * nw17;
    return t[15:8];
  endfunction

  assign rgb.r = blend_ch(spr.r, bg.r, ap);
  assign rgb.g = blend_ch(spr.g, bg.g, ap);
  assign rgb.b = blend_ch(spr.b, bg.b, ap);

endmodule

// File: rtl/sprite_merge_sched.sv
// Raster tracker, sprite arbiter and 3-stage blend pipeline with valid/ready output.
module sprite_merge_sched
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32
)(
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             bg_valid,
  output logic                                             bg_ready,
  input  logic                                             bg_sof,
  input  logic [23:0]                                      bg_rgb,
  input  logic                                             cfg_we,
  input  logic [$clog2(NUM_SPRITES)-1:0]                   cfg_idx,
  input  logic [9:0]                                       cfg_x,
  input  logic [9:0]                                       cfg_y,
  input  logic                                             cfg_en,
  output logic                                             spr_rd_en,
  output logic [spr_addr_w(NUM_SPRITES,SPR_H,SPR_W)-1:0]   spr_addr,
  input  logic [31:0]                                      spr_rgba,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [23:0]                                      out_rgb,
  output logic                                             out_sof
);

  localparam int STAGES = 2;
  localparam int IW = $clog2(NUM_SPRITES);
  localparam int RW = $clog2(SPR_H);
  localparam int CW = $clog2(SPR_W);
  localparam int AW = spr_addr_w(NUM_SPRITES, SPR_H, SPR_W);
  localparam logic [COORD_W:0]   SPR_W11 = (COORD_W+1)'(SPR_W);
  localparam logic [COORD_W:0]   SPR_H11 = (COORD_W+1)'(SPR_H);
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);

  logic                         run, advance, go, accept, swap;
  logic [STAGES:0]              vld_pipe;
  logic [COORD_W-1:0]           x_cnt, y_cnt, cur_x, cur_y, dx, dy;
  spr_cfg_t [NUM_SPRITES-1:0]   shadow, active, cfg_use;
  logic [NUM_SPRITES-1:0]       hit_vec;
  logic                         hit_any;
  logic [IW-1:0]                hit_idx;
  logic [AW-1:0]                addr_nxt;
  rgb_t                         s0_bg, s1_bg, blend_rgb;
  logic                         s0_hit, s1_hit, s0_sof, s1_sof;
  rgba_t                        spr_px;

  // Whole pipeline moves together; held off until the first edge after reset.
  assign advance   = !vld_pipe[STAGES] || out_ready;
  assign go        = run && advance;
  assign bg_ready  = go;
  assign spr_rd_en = go;
  assign accept    = go && bg_valid;
  assign swap      = accept && bg_sof;
  assign out_valid = vld_pipe[STAGES];

  // A sof pixel is (0,0) and sees the freshly swapped bank in the same cycle.
  assign cur_x   = bg_sof ? '0 : x_cnt;
  assign cur_y   = bg_sof ? '0 : y_cnt;
  assign cfg_use = swap ? shadow : active;

  // Per-slot window test; 11-bit compare keeps x+SPR_W from wrapping past 1023.
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
    logic [COORD_W:0] px, py, sx, sy;
    assign px = {1'b0, cur_x};
    assign py = {1'b0, cur_y};
    assign sx = {1'b0, cfg_use[i].x};
    assign sy = {1'b0, cfg_use[i].y};
    assign hit_vec[i] = cfg_use[i].en && (px >= sx) && (px < sx + SPR_W11) &&
                        (py >= sy) && (py < sy + SPR_H11);
  end

  // Fixed priority: lowest slot index owns the pixel.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign dx       = cur_x - cfg_use[hit_idx].x;
  assign dy       = cur_y - cfg_use[hit_idx].y;
  assign addr_nxt = {hit_idx, dy[RW-1:0], dx[CW-1:0]};

  // Release gate so bg_ready rises only on the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Raster position of the next pixel; sof resynchronises immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      if (cur_x == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= (cur_y == Y_LAST) ? '0 : cur_y + ONE;
      end else begin
        x_cnt <= cur_x + ONE;
        y_cnt <= cur_y;
      end
    end
  end

  // Shadow writes any time; active bank takes the pre-write shadow at sof.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (cfg_we) shadow[cfg_idx] <= '{x: cfg_x, y: cfg_y, en: cfg_en};
      if (swap)   active <= shadow;
    end
  end

  assign spr_px = spr_rgba;

  pixel_blend u_blend (
    .bg  (s1_bg),
    .spr (spr_px),
    .hit (s1_hit),
    .rgb (blend_rgb)
  );

  // S0 -> S1 -> S2 pipeline; the sprite read issued from S0 lands alongside S1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s0_bg    <= '0;
      s0_hit   <= 1'b0;
      s0_sof   <= 1'b0;
      s1_bg    <= '0;
      s1_hit   <= 1'b0;
      s1_sof   <= 1'b0;
      spr_addr <= '0;
      out_rgb  <= '0;
      out_sof  <= 1'b0;
    end else if (go) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], bg_valid};
      s0_bg    <= bg_rgb;
      s0_hit   <= hit_any;
      s0_sof   <= bg_valid && bg_sof;
      if (accept && hit_any) spr_addr <= addr_nxt;
      s1_bg    <= s0_bg;
      s1_hit   <= s0_hit;
      s1_sof   <= s0_sof;
      out_rgb  <= blend_rgb;
      out_sof  <= vld_pipe[STAGES-1] && s1_sof;
    end
  end

endmodule
